// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit
//   Iterative RV64M multiply/divide unit. One M-extension op is accepted over
//   valid/ready, computed radix-2 over XLEN CALC cycles (shift-add multiply or
//   restoring divide on operand magnitudes), sign-corrected, and held in
//   resp_data until the consumer takes it. Divide-by-zero and signed overflow
//   skip CALC and go straight to DONE.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   flush         synchronous abort of in-flight op and pending response
//   req_valid/req_ready, req_op (funct3), req_a (rs1), req_b (rs2)
//   resp_valid/resp_ready, resp_data
//   busy          high whenever the unit is not idle
module rv_muldiv_unit #(
  parameter int XLEN = 64,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        op_r;
  logic              neg_r;       // product / quotient needs negation
  logic              rem_neg_r;   // remainder takes the sign of a
  logic [XLEN-1:0]   opd_r;       // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_r;       // {hi, lo}: product/multiplier or remainder/quotient
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [XLEN-1:0]   resp_data_r;

  logic              accept_s;
  logic              a_sgn_s;
  logic              b_sgn_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shr_s;
  logic [XLEN:0]     div_diff_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_rem_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_res_s;

  assign req_ready  = (state_r == ST_IDLE) & ~flush;
  assign accept_s   = req_valid & req_ready;
  assign resp_valid = (state_r == ST_DONE);
  assign busy       = (state_r != ST_IDLE);
  assign resp_data  = resp_data_r;

  // Request decode: operand signedness, magnitudes and fast-path detection.
  always_comb begin
    a_sgn_s = (req_op == OP_MUL) | (req_op == OP_MULH) | (req_op == OP_MULHSU) |
              (req_op == OP_DIV) | (req_op == OP_REM);
    b_sgn_s = (req_op == OP_MUL) | (req_op == OP_MULH) |
              (req_op == OP_DIV) | (req_op == OP_REM);
    a_neg_s = a_sgn_s & req_a[XLEN-1];
    b_neg_s = b_sgn_s & req_b[XLEN-1];
    // -2^(XLEN-1) negates to itself, which is the correct unsigned magnitude.
    a_mag_s = a_neg_s ? (~req_a + ONE_X) : req_a;
    b_mag_s = b_neg_s ? (~req_b + ONE_X) : req_b;
    special_res_s = ZERO_X;
    special_s     = 1'b0;
    if (req_op[2] && (req_b == ZERO_X)) begin
      special_s     = 1'b1;
      special_res_s = req_op[1] ? req_a : ONES_X;
    end else if (((req_op == OP_DIV) || (req_op == OP_REM)) &&
                 (req_a == MIN_X) && (req_b == ONES_X)) begin
      special_s     = 1'b1;
      special_res_s = req_op[1] ? ZERO_X : req_a;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_X;
    end
  end

  // One radix-2 iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opd_r} : {(XLEN+1){1'b0}});
    // Shifted partial remainder needs XLEN+1 bits: it can reach 2*divisor-1.
    div_shr_s  = acc_r[2*XLEN-1:XLEN-1];
    div_diff_s = div_shr_s - {1'b0, opd_r};
    div_ge_s   = ~div_diff_s[XLEN];
    div_rem_s  = div_ge_s ? div_diff_s[XLEN-1:0] : div_shr_s[XLEN-1:0];
    if (op_r[2]) begin
      acc_nxt_s = {div_rem_s, acc_r[XLEN-2:0], div_ge_s};
    end else begin
      acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign correction and result selection applied to the final iteration.
  always_comb begin
    prod_s = neg_r ? (~acc_nxt_s + ONE_2X) : acc_nxt_s;
    quo_s  = neg_r ? (~acc_nxt_s[XLEN-1:0] + ONE_X) : acc_nxt_s[XLEN-1:0];
    rem_s  = rem_neg_r ? (~acc_nxt_s[2*XLEN-1:XLEN] + ONE_X) : acc_nxt_s[2*XLEN-1:XLEN];
    case (op_r)
      OP_MUL:    final_res_s = prod_s[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  final_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU:   final_res_s = quo_s;
      OP_REM,
      OP_REMU:   final_res_s = rem_s;
      default:   final_res_s = ZERO_X;
    endcase
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = special_s ? ST_DONE : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture on accept and iteration datapath during CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 3'b000;
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
      opd_r     <= ZERO_X;
      acc_r     <= {(2*XLEN){1'b0}};
    end else if (accept_s) begin
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= req_op;
      neg_r     <= a_neg_s ^ b_neg_s;
      rem_neg_r <= a_neg_s;
      opd_r     <= req_op[2] ? b_mag_s : a_mag_s;
      acc_r     <= {ZERO_X, (req_op[2] ? a_mag_s : b_mag_s)};
    end else if (state_r == ST_CALC) begin
      cnt_r <= cnt_r + CNT_ONE;
      acc_r <= acc_nxt_s;
    end
  end

  // Result register: written by the fast path or by the last CALC edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_r <= ZERO_X;
    end else if (accept_s && special_s) begin
      resp_data_r <= special_res_s;
    end else if ((state_r == ST_CALC) && (cnt_r == CNT_LAST) && !flush) begin
      resp_data_r <= final_res_s;
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit
//   Directed bench for rv_muldiv_unit at XLEN=64: reset values, every op with
//   hand-computed results, latency of normal and fast-path ops, response
//   backpressure, flush mid-CALC and asynchronous reset mid-CALC.
module tb_rv_muldiv_unit;
  localparam int XLEN = 64;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = 3'b000;
  logic [XLEN-1:0] req_a = 64'h0;
  logic [XLEN-1:0] req_b = 64'h0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  rv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; it is accepted at the next posedge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count edges until resp_valid, noting whether req_ready ever rose meanwhile.
  task automatic wait_resp(output int n, output logic rdy_low);
    n = 0;
    rdy_low = 1'b1;
    while (resp_valid !== 1'b1 && n < 300) begin
      if (req_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int   n;
    logic rl;
    issue(op, a, b);
    wait_resp(n, rl);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_rdy_low"}, {63'd0, rl}, 64'd1);
    check({tag, "_data"}, resp_data, exp);
    take();
    check({tag, "_done"}, {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    int   n;
    logic rl;
    logic ok;

    // Reset values
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    #11 rst = 1'b0;
    #1 check("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Multiply
    run_op("mul", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64);
    run_op("mulh", OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64);
    run_op("mulhu", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    run_op("mulhsu", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run_op("mulhsu_pos", OP_MULHSU, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 64);

    // Divide
    run_op("div", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
    run_op("rem", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run_op("divu", OP_DIVU, 64'd100, 64'd7, 64'd14, 64);
    run_op("remu", OP_REMU, 64'd100, 64'd7, 64'd2, 64);
    run_op("div_negb", OP_DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 64);

    // Fast path
    run_op("divu_z", OP_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remu_z", OP_REMU, 64'd5, 64'd0, 64'd5, 0);
    run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0);
    run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);

    // Backpressure: hold result 5 cycles with a competing request pending
    issue(OP_MUL, 64'd3, 64'd5);
    wait_resp(n, rl);
    check("bp_lat", 64'(n), 64'd64);
    req_op = OP_DIVU; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (resp_data !== 64'd15 || busy !== 1'b1 || resp_valid !== 1'b1 || req_ready !== 1'b0) ok = 1'b0;
    end
    check("bp_hold", {63'd0, ok}, 64'd1);
    check("bp_data", resp_data, 64'd15);
    take();
    check("bp_release_valid", {63'd0, resp_valid}, 64'd0);
    check("bp_release_busy", {63'd0, busy}, 64'd0);
    check("bp_release_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp_next_accepted", {63'd0, busy}, 64'd1);
    wait_resp(n, rl);
    check("bp_next_lat", 64'(n), 64'd64);
    check("bp_next_data", resp_data, 64'd14);
    take();

    // Flush at CALC iteration 20
    issue(OP_MUL, 64'd9, 64'd9);
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_req_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_valid", {63'd0, resp_valid}, 64'd0);
    ok = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("flush_quiet", {63'd0, ok}, 64'd1);
    run_op("mul_after_flush", OP_MUL, 64'd3, 64'd4, 64'd12, 64);

    // Asynchronous reset mid-CALC
    issue(OP_DIV, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_valid", {63'd0, resp_valid}, 64'd0);
    check("arst_data", resp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("arst_req_ready", {63'd0, req_ready}, 64'd1);
    run_op("rem_after_rst", OP_REM, 64'd1000, 64'd3, 64'd1, 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Iterative RV64M multiply/divide execution unit, parametrised in XLEN.
- Sits beside the single-cycle 64-bit ALU in the execute stage. Accepts one M-extension operation via valid/ready, computes it radix-2 over XLEN cycles, and holds the result until the consumer takes it.
- Implements the RISC-V special-case results for divide-by-zero and signed overflow in a single-cycle fast path.

Parameters:
- XLEN, 64, operand/result width; legal values are any even integer >= 8.
- CNT_W, $clog2(XLEN), width of the iteration counter (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of the in-flight op and any pending response.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_op  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  input  XLEN  rs1 operand.
- req_b  input  XLEN  rs2 operand.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  XLEN  result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async): state=IDLE; counter=0; resp_valid=0; resp_data=0; busy=0; req_ready=1 once rst deasserts.
- States: IDLE, CALC, DONE.
- Handshakes:
  - req_ready = (state==IDLE) & ~flush.
  - Accept occurs on an edge where req_valid & req_ready; op, operands and sign information are latched at that edge.
  - resp_valid = (state==DONE).
  - While resp_valid=1 and resp_ready=0, resp_data is held stable.
- Transitions:
  - IDLE -> DONE on accept, if the op is special (divide by zero, or signed overflow on DIV/REM).
  - IDLE -> CALC on accept, otherwise.
  - CALC -> DONE at the edge where counter==XLEN-1; the final result, including sign correction, is written to resp_data at that edge.
  - DONE -> IDLE on resp_valid & resp_ready.
  - No request is accepted in DONE or CALC.
- Latency:
  - Normal ops: resp_valid is first high in the cycle after the XLEN-th edge following the accepting edge.
  - Special ops: resp_valid is high in the cycle immediately after the accepting edge.
- Multiply:
  - Operands are converted to magnitudes: MUL/MULH treat both signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
  - Shift-add runs into a 2*XLEN accumulator, one multiplier bit per CALC cycle.
  - The 2*XLEN product is negated if the operand signs differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) xor sign(b) (signed ops only).
  - Remainder takes the sign of a (signed ops only).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases:
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): DIV returns a; REM returns 0.
- Flush:
  - flush=1 forces state=IDLE and resp_valid=0 at the next edge from any state.
  - No accept occurs in a flush cycle.
  - resp_data keeps its last value (don't-care).
- Reset mid-CALC or mid-DONE returns to IDLE immediately; the in-flight op is lost and no response is produced.
- Simultaneous resp_ready and req_valid in DONE: the response completes; the request is accepted no earlier than the following IDLE cycle.

Test Plan:
- Basic MUL (XLEN=64): MUL a=7, b=-3 -> resp_data 0xFFFFFFFFFFFFFFEB. resp_valid first high 64 cycles after accept; req_ready low throughout.
- High products:
  - MULH a=b=0x8000000000000000 -> 0x4000000000000000.
  - MULHU a=b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
  - MULHSU a=-1, b=2 -> 0xFFFFFFFFFFFFFFFF.
- Signed division:
  - DIV a=-7, b=2 -> 0xFFFFFFFFFFFFFFFD.
  - REM a=-7, b=2 -> 0xFFFFFFFFFFFFFFFF.
  - DIVU a=100, b=7 -> 14.
  - REMU a=100, b=7 -> 2.
- Special fast path, each with resp_valid in the cycle right after accept:
  - DIVU 5/0 -> all-ones.
  - REMU 5/0 -> 5.
  - DIV 0x8000000000000000 / -1 -> 0x8000000000000000.
  - REM of the same operands -> 0.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_data stable, busy=1, and a new req_valid is not accepted; release -> IDLE the next cycle, and the next request is accepted.
- Abort and reset:
  - Flush at CALC iteration 20 -> IDLE next cycle with no resp_valid; a subsequent MUL 3*4 returns 12.
  - Async rst pulsed mid-CALC -> outputs at reset values immediately.
